// File: rtl/rank_filter_pkg.sv
// rank_filter_pkg: shared constants for the 3x3 rank filter
// mode encodings and window geometry
package rank_filter_pkg;

  localparam logic [1:0] MODE_MED = 2'd0;
  localparam logic [1:0] MODE_MIN = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;
  localparam logic [1:0] MODE_CTR = 2'd3;

  localparam int WIN_N = 9;

endpackage

// File: rtl/sort3.sv
// sort3: combinational three-input sorter
// orders a, b, c into hi >= md >= lo
module sort3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] md,
  output logic [DATA_W-1:0] lo
);

  function automatic logic gt(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y
  );
    if (SIGNED != 0) return $signed(x) > $signed(y);
    return x > y;
  endfunction

  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] y1;
  logic [DATA_W-1:0] t;

  // three compare-exchange steps
  always_comb begin
    x1 = gt(a, b) ? a : b;
    y1 = gt(a, b) ? b : a;
    hi = gt(x1, c) ? x1 : c;
    t  = gt(x1, c) ? c : x1;
    md = gt(y1, t) ? y1 : t;
    lo = gt(y1, t) ? t : y1;
  end

endmodule

// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: pipelined 3x3 rank filter
// one window per cycle, median/min/max/centre
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIGNED = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIN_N*DATA_W-1:0] win_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [1:0]              out_mode
);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic logic gt(
    input pix_t x,
    input pix_t y
  );
    if (SIGNED != 0) return $signed(x) > $signed(y);
    return x > y;
  endfunction

  function automatic pix_t max3(
    input pix_t x,
    input pix_t y,
    input pix_t z
  );
    pix_t m;
    m = gt(x, y) ? x : y;
    return gt(m, z) ? m : z;
  endfunction

  function automatic pix_t min3(
    input pix_t x,
    input pix_t y,
    input pix_t z
  );
    pix_t m;
    m = gt(x, y) ? y : x;
    return gt(m, z) ? z : m;
  endfunction

  logic en;

  // whole pipe moves unless the output is stalled
  always_comb en = !out_valid || out_ready;

  assign in_ready = en && !RST;

  pix_t col_hi [3];
  pix_t col_md [3];
  pix_t col_lo [3];

  for (genvar g = 0; g < 3; g++) begin : g_col
    sort3 #(
      .DATA_W(DATA_W),
      .SIGNED(SIGNED)
    ) u_col (
      .a (win_data[g*DATA_W +: DATA_W]),
      .b (win_data[(g+3)*DATA_W +: DATA_W]),
      .c (win_data[(g+6)*DATA_W +: DATA_W]),
      .hi(col_hi[g]),
      .md(col_md[g]),
      .lo(col_lo[g])
    );
  end

  logic       s1_valid;
  logic [1:0] s1_mode;
  pix_t       s1_ctr;
  pix_t       s1_hi [3];
  pix_t       s1_md [3];
  pix_t       s1_lo [3];

  // stage 1: column-sorted window
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_ctr   <= '0;
      for (int i = 0; i < 3; i++) begin
        s1_hi[i] <= '0;
        s1_md[i] <= '0;
        s1_lo[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_ctr   <= win_data[4*DATA_W +: DATA_W];
      for (int i = 0; i < 3; i++) begin
        s1_hi[i] <= col_hi[i];
        s1_md[i] <= col_md[i];
        s1_lo[i] <= col_lo[i];
      end
    end
  end

  pix_t mom;
  pix_t mom_hi_unused;
  pix_t mom_lo_unused;

  sort3 #(
    .DATA_W(DATA_W),
    .SIGNED(SIGNED)
  ) u_mom (
    .a (s1_md[0]),
    .b (s1_md[1]),
    .c (s1_md[2]),
    .hi(mom_hi_unused),
    .md(mom),
    .lo(mom_lo_unused)
  );

  logic       s2_valid;
  logic [1:0] s2_mode;
  pix_t       s2_ctr;
  pix_t       s2_a;
  pix_t       s2_b;
  pix_t       s2_c;
  pix_t       s2_mx;
  pix_t       s2_mn;

  // stage 2: median candidates plus global extremes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_mode  <= '0;
      s2_ctr   <= '0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_c     <= '0;
      s2_mx    <= '0;
      s2_mn    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_ctr   <= s1_ctr;
      s2_a     <= min3(s1_hi[0], s1_hi[1], s1_hi[2]);
      s2_b     <= mom;
      s2_c     <= max3(s1_lo[0], s1_lo[1], s1_lo[2]);
      s2_mx    <= max3(s1_hi[0], s1_hi[1], s1_hi[2]);
      s2_mn    <= min3(s1_lo[0], s1_lo[1], s1_lo[2]);
    end
  end

  pix_t fin_med;
  pix_t fin_hi_unused;
  pix_t fin_lo_unused;

  sort3 #(
    .DATA_W(DATA_W),
    .SIGNED(SIGNED)
  ) u_fin (
    .a (s2_a),
    .b (s2_b),
    .c (s2_c),
    .hi(fin_hi_unused),
    .md(fin_med),
    .lo(fin_lo_unused)
  );

  pix_t res;

  // pick the rank the window asked for
  always_comb begin
    res = s2_ctr;
    unique case (s2_mode)
      MODE_MED: res = fin_med;
      MODE_MIN: res = s2_mn;
      MODE_MAX: res = s2_mx;
      MODE_CTR: res = s2_ctr;
    endcase
  end

  // stage 3: output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_data  <= res;
      out_mode  <= s2_mode;
    end
  end

endmodule

// File: tb/tb_rank_filter_3x3.sv
// tb_rank_filter_3x3: directed and random checks
// 8-bit unsigned and 12-bit signed instances
module tb_rank_filter_3x3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready;
  logic [71:0] a_win;
  logic [1:0]  a_mode;
  logic        a_out_valid, a_out_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_mode;

  logic         b_in_valid, b_in_ready;
  logic [107:0] b_win;
  logic [1:0]   b_mode;
  logic         b_out_valid, b_out_ready;
  logic [11:0]  b_out_data;
  logic [1:0]   b_out_mode;

  rank_filter_3x3 #(.DATA_W(8), .SIGNED(0)) dut_a (
    .CLK(clk), .RST(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .win_data(a_win), .in_mode(a_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_mode(a_out_mode)
  );

  rank_filter_3x3 #(.DATA_W(12), .SIGNED(1)) dut_b (
    .CLK(clk), .RST(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .win_data(b_win), .in_mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_mode(b_out_mode)
  );

  int vec = 0;
  int bad = 0;

  // windows are held as nine 16-bit slots, truncated per DUT
  function automatic logic [15:0] ref_val(
    input logic [143:0] w, input int wid,
    input bit sgn, input logic [1:0] m);
    int k[9];
    int raw, ctr, t, mask, tmp;
    mask = (1 << wid) - 1;
    for (int i = 0; i < 9; i++) begin
      raw = int'(w[i*16 +: 16]) & mask;
      if (sgn && (((raw >> (wid - 1)) & 1) == 1))
        raw = raw - (1 << wid);
      k[i] = raw;
    end
    ctr = k[4];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (k[j] > k[j+1]) begin
          tmp = k[j]; k[j] = k[j+1]; k[j+1] = tmp;
        end
    case (m)
      2'd0: t = k[4];
      2'd1: t = k[0];
      2'd2: t = k[8];
      default: t = ctr;
    endcase
    return 16'(t & mask);
  endfunction

  function automatic logic [143:0] mkwin(input int p[9]);
    logic [143:0] w;
    for (int i = 0; i < 9; i++) w[i*16 +: 16] = 16'(p[i]);
    return w;
  endfunction

  function automatic logic [143:0] rndwin();
    logic [143:0] w;
    for (int i = 0; i < 9; i++)
      if ($urandom_range(0, 3) == 0)
        w[i*16 +: 16] = 16'($urandom_range(0, 3));
      else
        w[i*16 +: 16] = 16'($urandom);
    return w;
  endfunction

  function automatic logic [71:0] pack8(input logic [143:0] w);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = w[i*16 +: 8];
    return r;
  endfunction

  function automatic logic [107:0] pack12(input logic [143:0] w);
    logic [107:0] r;
    for (int i = 0; i < 9; i++) r[i*12 +: 12] = w[i*16 +: 12];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; b_in_valid = 1'b1;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_win = pack8(rndwin()); b_win = pack12(rndwin());
    a_mode = 2'd2; b_mode = 2'd1;
    tick(); tick();
    vec += 6;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_a_in_ready got %b want 0", a_in_ready);
    end
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_a_out_valid got %b want 0", a_out_valid);
    end
    if (a_out_data !== 8'd0) begin
      bad++; $display("FAIL rst_a_out_data got %0h want 0", a_out_data);
    end
    if (a_out_mode !== 2'd0) begin
      bad++; $display("FAIL rst_a_out_mode got %0d want 0", a_out_mode);
    end
    if (b_in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_b_in_ready got %b want 0", b_in_ready);
    end
    if (b_out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_b_out_valid got %b want 0", b_out_valid);
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst = 1'b0;
    tick();
    vec++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL post_rst_valid got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_latency();
    int px[9];
    int n;
    px = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    a_win = pack8(mkwin(px)); a_mode = 2'd0;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    vec++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL lat_in_ready got %b want 1", a_in_ready);
    end
    tick();
    a_in_valid = 1'b0;
    n = 1;
    while (!a_out_valid && n < 10) begin tick(); n++; end
    vec += 3;
    if (n != 3) begin
      bad++; $display("FAIL latency got %0d want 3", n);
    end
    if (a_out_data !== 8'd5) begin
      bad++; $display("FAIL lat_median got %0d want 5", a_out_data);
    end
    if (a_out_mode !== 2'd0) begin
      bad++; $display("FAIL lat_mode got %0d want 0", a_out_mode);
    end
    tick();
    vec++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL bubble_valid got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_modes();
    int px[9];
    int ex[4];
    int got[$];
    int at[$];
    px = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    ex = '{5, 1, 9, 7};
    a_win = pack8(mkwin(px));
    for (int c = 0; c < 10; c++) begin
      a_in_valid = (c < 4);
      a_mode = 2'(c);
      tick();
      if (a_out_valid) begin
        got.push_back(int'(a_out_data)); at.push_back(c);
      end
    end
    a_in_valid = 1'b0;
    vec++;
    if (got.size() != 4) begin
      bad++; $display("FAIL modes_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vec++;
      if (got[i] != ex[i] || at[i] != 2 + i) begin
        bad++;
        $display("FAIL modes_%0d got %0d@%0d want %0d@%0d",
                 i, got[i], at[i], ex[i], 2 + i);
      end
    end
  endtask

  task automatic test_signed();
    int px[9];
    int ex[4];
    int got[$];
    int n;
    logic [143:0] w;
    logic [15:0] e;
    px = '{-128, 127, -1, 0, 1, -2, 2, -3, 3};
    ex = '{0, 'hF80, 127, 1};
    w = mkwin(px);
    b_win = pack12(w);
    for (int c = 0; c < 10; c++) begin
      b_in_valid = (c < 4);
      b_mode = 2'(c);
      tick();
      if (b_out_valid) got.push_back(int'(b_out_data));
    end
    b_in_valid = 1'b0;
    vec++;
    if (got.size() != 4) begin
      bad++; $display("FAIL signed_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vec++;
      if (got[i] != ex[i]) begin
        bad++;
        $display("FAIL signed_%0d got %0h want %0h", i, got[i], ex[i]);
      end
    end
    // same bit patterns read as unsigned on the 8-bit instance
    e = ref_val(w, 8, 1'b0, 2'd0);
    a_win = pack8(w); a_mode = 2'd0; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 1;
    while (!a_out_valid && n < 10) begin tick(); n++; end
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== e[7:0]) begin
      bad++;
      $display("FAIL unsigned_bits got %0h want %0h", a_out_data, e[7:0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [17:0] q[$];
    logic [17:0] x;
    logic [143:0] w;
    logic [1:0] m;
    logic [15:0] e;
    logic pv;
    logic [7:0] pd;
    logic [1:0] pm;
    int sent, rcv;
    sent = 0; rcv = 0; pv = 1'b0; pd = '0; pm = '0;
    w = rndwin(); m = 2'($urandom);
    for (int c = 0; c < 60 && rcv < 10; c++) begin
      a_in_valid = (sent < 10);
      a_win = pack8(w); a_mode = m;
      a_out_ready = !(c >= 4 && c <= 7);
      #1;
      if (pv) begin
        vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== pd
            || a_out_mode !== pm) begin
          bad++;
          $display("FAIL bp_hold got %b/%0h/%0d want 1/%0h/%0d",
                   a_out_valid, a_out_data, a_out_mode, pd, pm);
        end
      end
      if (a_out_valid && !a_out_ready) begin
        vec++;
        if (a_in_ready !== 1'b0) begin
          bad++; $display("FAIL bp_in_ready got %b want 0", a_in_ready);
        end
      end
      if (a_in_valid && a_in_ready) begin
        e = ref_val(w, 8, 1'b0, m);
        q.push_back({m, e});
        sent++;
        w = rndwin(); m = 2'($urandom);
      end
      if (a_out_valid && a_out_ready) begin
        vec++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra got %0h want none", a_out_data);
        end else begin
          x = q.pop_front();
          if (a_out_data !== x[7:0] || a_out_mode !== x[17:16]) begin
            bad++;
            $display("FAIL bp_data got %0h/%0d want %0h/%0d",
                     a_out_data, a_out_mode, x[7:0], x[17:16]);
          end
        end
        rcv++;
      end
      pv = a_out_valid && !a_out_ready;
      pd = a_out_data; pm = a_out_mode;
      tick();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    vec++;
    if (rcv != 10) begin
      bad++; $display("FAIL bp_count got %0d want 10", rcv);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [143:0] w;
    logic [15:0] e;
    int cnt, n;
    a_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_win = pack8(rndwin()); a_mode = 2'(c);
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    vec++;
    if (a_out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre_valid got %b want 1", a_out_valid);
    end
    rst = 1'b1;
    #1;
    vec += 3;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_valid got %b want 0", a_out_valid);
    end
    if (a_out_data !== 8'd0) begin
      bad++; $display("FAIL mid_data got %0h want 0", a_out_data);
    end
    if (a_in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_in_ready got %b want 0", a_in_ready);
    end
    tick(); tick();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (a_out_valid) cnt++;
    end
    vec++;
    if (cnt != 0) begin
      bad++; $display("FAIL mid_stale got %0d want 0", cnt);
    end
    w = rndwin();
    e = ref_val(w, 8, 1'b0, 2'd2);
    a_win = pack8(w); a_mode = 2'd2; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 1;
    while (!a_out_valid && n < 10) begin tick(); n++; end
    vec++;
    if (n != 3 || a_out_data !== e[7:0]) begin
      bad++;
      $display("FAIL mid_next got %0h@%0d want %0h@3",
               a_out_data, n, e[7:0]);
    end
    tick();
  endtask

  task automatic test_random();
    localparam int NA = 2000;
    localparam int NB = 10000;
    logic [17:0] qa[$];
    logic [17:0] qb[$];
    logic [17:0] x;
    logic [143:0] wa, wb;
    logic [1:0] ma, mb;
    logic [15:0] e;
    int sa, sb, ra, rb;
    sa = 0; sb = 0; ra = 0; rb = 0;
    wa = rndwin(); wb = rndwin();
    ma = 2'($urandom); mb = 2'($urandom);
    for (int c = 0; c < 60000 && (ra < NA || rb < NB); c++) begin
      a_in_valid = (sa < NA) && ($urandom_range(0, 3) != 0);
      a_win = pack8(wa); a_mode = ma;
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = (sb < NB) && ($urandom_range(0, 3) != 0);
      b_win = pack12(wb); b_mode = mb;
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (a_in_valid && a_in_ready) begin
        e = ref_val(wa, 8, 1'b0, ma);
        qa.push_back({ma, e});
        sa++;
        wa = rndwin(); ma = 2'($urandom);
      end
      if (b_in_valid && b_in_ready) begin
        e = ref_val(wb, 12, 1'b1, mb);
        qb.push_back({mb, e});
        sb++;
        wb = rndwin(); mb = 2'($urandom);
      end
      if (a_out_valid && a_out_ready) begin
        vec++;
        if (qa.size() == 0) begin
          bad++; $display("FAIL rnd_a_extra got %0h want none", a_out_data);
        end else begin
          x = qa.pop_front();
          if (a_out_data !== x[7:0] || a_out_mode !== x[17:16]) begin
            bad++;
            $display("FAIL rnd_a got %0h/%0d want %0h/%0d",
                     a_out_data, a_out_mode, x[7:0], x[17:16]);
          end
        end
        ra++;
      end
      if (b_out_valid && b_out_ready) begin
        vec++;
        if (qb.size() == 0) begin
          bad++; $display("FAIL rnd_b_extra got %0h want none", b_out_data);
        end else begin
          x = qb.pop_front();
          if (b_out_data !== x[11:0] || b_out_mode !== x[17:16]) begin
            bad++;
            $display("FAIL rnd_b got %0h/%0d want %0h/%0d",
                     b_out_data, b_out_mode, x[11:0], x[17:16]);
          end
        end
        rb++;
      end
      tick();
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    vec += 2;
    if (ra != NA || qa.size() != 0) begin
      bad++; $display("FAIL rnd_a_count got %0d want %0d", ra, NA);
    end
    if (rb != NB || qb.size() != 0) begin
      bad++; $display("FAIL rnd_b_count got %0d want %0d", rb, NB);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_win = '0; a_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_win = '0; b_mode = '0; b_out_ready = 1'b1;
    test_reset();
    test_latency();
    test_modes();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
